mdr_buffer: RTL

- Parametrised successor to the single-word memory data register.
- Sits between the internal data bus and the memory port.
- Holds two independent DEPTH-entry FIFOs: a write path (bus to memory) and a read path (memory to bus).
- Each side uses valid/ready handshakes, so bus and memory traffic can overlap and stall independently; includes a synchronous flush.

---
 rtl/mdr_pkg.sv | 25 ++
 rtl/mdr_buffer_if.sv | 52 +++++
 rtl/mdr_fifo_core.sv | 74 +++++++
 rtl/mdr_buffer.sv | 75 +++++++
 4 files changed

// File: rtl/mdr_pkg.sv
// ============================================================================
// Module      : mdr_pkg
// Description : Shared constants and helpers for the memory data register
//               buffer (default sizes, count width, handshake fire).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mdr_pkg;

    localparam int c_DEF_DATA_W = 16;
    localparam int c_DEF_DEPTH  = 4;

    // Occupancy must be able to represent DEPTH itself, hence DEPTH+1 states.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic logic fire(input logic valid, input logic ready);
        return valid && ready;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mdr_buffer_if.sv
// ============================================================================
// Module      : mdr_buffer_if
// Description : Bus-side and memory-side valid/ready handshake bundle for
//               mdr_buffer. slave = buffer view, master = environment view.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mdr_buffer_if
    import mdr_pkg::*;
#(
    parameter int DATA_W = c_DEF_DATA_W
);

    logic [DATA_W-1:0] bus_wr_data;
    logic              bus_wr_valid;
    logic              bus_wr_ready;
    logic [DATA_W-1:0] mem_wr_data;
    logic              mem_wr_valid;
    logic              mem_wr_ready;
    logic [DATA_W-1:0] mem_rd_data;
    logic              mem_rd_valid;
    logic              mem_rd_ready;
    logic [DATA_W-1:0] bus_rd_data;
    logic              bus_rd_valid;
    logic              bus_rd_ready;

    modport slave (
        input  bus_wr_data, bus_wr_valid,
        output bus_wr_ready,
        output mem_wr_data, mem_wr_valid,
        input  mem_wr_ready,
        input  mem_rd_data, mem_rd_valid,
        output mem_rd_ready,
        output bus_rd_data, bus_rd_valid,
        input  bus_rd_ready
    );

    modport master (
        output bus_wr_data, bus_wr_valid,
        input  bus_wr_ready,
        input  mem_wr_data, mem_wr_valid,
        output mem_wr_ready,
        output mem_rd_data, mem_rd_valid,
        input  mem_rd_ready,
        input  bus_rd_data, bus_rd_valid,
        output bus_rd_ready
    );

endinterface

`default_nettype wire

// File: rtl/mdr_fifo_core.sv
// ============================================================================
// Module      : mdr_fifo_core
// Description : DEPTH-entry first-word-fall-through FIFO with valid/ready on
//               both sides, synchronous flush and async active-low reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdr_fifo_core
    import mdr_pkg::*;
#(
    parameter  int DATA_W = c_DEF_DATA_W,
    parameter  int DEPTH  = c_DEF_DEPTH,
    localparam int CNT_W  = cnt_width(DEPTH)
) (
    input  wire logic              clock,
    input  wire logic              reset,
    input  wire logic              flush,
    input  wire logic [DATA_W-1:0] in_data,
    input  wire logic              in_valid,
    output      logic              in_ready,
    output      logic [DATA_W-1:0] out_data,
    output      logic              out_valid,
    input  wire logic              out_ready,
    output      logic [CNT_W-1:0]  count
);

    localparam int               c_PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] c_FULL  = CNT_W'(DEPTH);

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_push;
    logic               w_pop;

    // Ready/valid come only from the registered count, never from the peer.
    assign in_ready  = (r_count != c_FULL);
    assign out_valid = (r_count != '0);
    assign out_data  = r_mem[r_rd_ptr];
    assign count     = r_count;

    assign w_push = fire(in_valid, in_ready);
    assign w_pop  = fire(out_valid, out_ready);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; only pointers and count define contents.
    always_ff @(posedge clock) begin
        if (w_push && !flush) r_mem[r_wr_ptr] <= in_data;
    end

endmodule

`default_nettype wire

// File: rtl/mdr_buffer.sv
// ============================================================================
// Module      : mdr_buffer
// Description : Dual FIFO memory data register (write path bus->memory, read
//               path memory->bus). Define MDR_TRISTATE_EN to float idle data.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdr_buffer
    import mdr_pkg::*;
#(
    parameter  int DATA_W = c_DEF_DATA_W,
    parameter  int DEPTH  = c_DEF_DEPTH,
    localparam int CNT_W  = cnt_width(DEPTH)
) (
    input  wire logic       clock,
    input  wire logic       reset,
    input  wire logic       flush,
    mdr_buffer_if.slave     io,
    output      logic [CNT_W-1:0] wr_count,
    output      logic [CNT_W-1:0] rd_count
);

    logic [DATA_W-1:0] w_wr_head;
    logic [DATA_W-1:0] w_rd_head;
    logic              w_wr_valid;
    logic              w_rd_valid;

    mdr_fifo_core #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_wr_path (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_data   (io.bus_wr_data),
        .in_valid  (io.bus_wr_valid),
        .in_ready  (io.bus_wr_ready),
        .out_data  (w_wr_head),
        .out_valid (w_wr_valid),
        .out_ready (io.mem_wr_ready),
        .count     (wr_count)
    );

    mdr_fifo_core #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_rd_path (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_data   (io.mem_rd_data),
        .in_valid  (io.mem_rd_valid),
        .in_ready  (io.mem_rd_ready),
        .out_data  (w_rd_head),
        .out_valid (w_rd_valid),
        .out_ready (io.bus_rd_ready),
        .count     (rd_count)
    );

    assign io.mem_wr_valid = w_wr_valid;
    assign io.bus_rd_valid = w_rd_valid;

    // Unreset storage must never leak onto the ports while a path is empty.
`ifdef MDR_TRISTATE_EN
    assign io.mem_wr_data = w_wr_valid ? w_wr_head : {DATA_W{1'bz}};
    assign io.bus_rd_data = w_rd_valid ? w_rd_head : {DATA_W{1'bz}};
`else
    assign io.mem_wr_data = w_wr_valid ? w_wr_head : '0;
    assign io.bus_rd_data = w_rd_valid ? w_rd_head : '0;
`endif

endmodule

`default_nettype wire
